// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard sequencing logic.
package pipeline_pkg;

  localparam int unsigned STALL_REQ_W = 2;

  // Requested stall lengths from hazard detection; 2'd3 behaves as STALL_TWO.
  localparam logic [STALL_REQ_W-1:0] STALL_NONE = 2'd0;
  localparam logic [STALL_REQ_W-1:0] STALL_ONE  = 2'd1;
  localparam logic [STALL_REQ_W-1:0] STALL_TWO  = 2'd2;

  typedef enum logic [0:0] {
    CTRL_RUN    = 1'b0,
    CTRL_STALL2 = 1'b1
  } ctrl_state_t;

endpackage : pipeline_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipeline_controller.sv
// Hazard sequencing controller: turns stall/flush/memory-wait requests into
// stage-register write enables and bubble/flush controls. Optional performance
// counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STALL_REQ_W-1:0] ID_StallReq,
  input  logic                   ID_FlushReq,
  input  logic                   IF_MemBusy,
  input  logic                   MEM_MemBusy,
  output logic                   PC_Write,
  output logic                   PC_Redirect,
  output logic                   IFID_Write,
  output logic                   IFID_Flush,
  output logic                   IDEX_Bubble,
  output logic                   IDEX_Write,
  output logic                   EXMEM_Write,
  output logic                   MEMWB_Write,
  output logic                   Stall_Active
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]  Perf_StallCycles,
  output logic [PERF_WIDTH-1:0]  Perf_Flushes,
  output logic [PERF_WIDTH-1:0]  Perf_FreezeCycles
`endif
);

  ctrl_state_t state;
  ctrl_state_t state_next;

  // Reject a zero-width counter configuration at elaboration.
  if (PERF_WIDTH < 1) begin : g_bad_perf_width
    $error("pipeline_controller: PERF_WIDTH must be at least 1");
  end

  // State register; reset discards any pending second stall cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CTRL_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Priority-ordered control decode and next-state logic.
  always_comb begin
    PC_Write     = 1'b1;
    PC_Redirect  = 1'b0;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    MEMWB_Write  = 1'b1;
    Stall_Active = 1'b0;
    state_next   = state;

    if (reset) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Bubble = 1'b1;
      state_next = CTRL_RUN;
    end else if (MEM_MemBusy) begin
      // Freeze: hold every stage; pending requests are re-presented later.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
    end else if (state == CTRL_STALL2) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Bubble  = 1'b1;
      Stall_Active = 1'b1;
      state_next   = CTRL_RUN;
    end else if (ID_StallReq != STALL_NONE) begin
      // Branch operands are stale while stalling, so a flush is not honoured.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      if (ID_StallReq >= STALL_TWO) begin
        state_next = CTRL_STALL2;
      end
    end else if (ID_FlushReq) begin
      // Redirect wins over an outstanding fetch; that fetch is abandoned.
      PC_Redirect = 1'b1;
      IFID_Flush  = 1'b1;
    end else if (IF_MemBusy) begin
      PC_Write   = 1'b0;
      IFID_Flush = 1'b1;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;
  logic freeze_inc;

  // Qualify each counter with the decode rule it tracks.
  always_comb begin
    freeze_inc = !reset && MEM_MemBusy;
    stall_inc  = !reset && !MEM_MemBusy &&
                 ((state == CTRL_STALL2) || (ID_StallReq != STALL_NONE));
    flush_inc  = !reset && !MEM_MemBusy && (state == CTRL_RUN) &&
                 (ID_StallReq == STALL_NONE) && ID_FlushReq;
  end

  sat_counter #(.WIDTH(PERF_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (Perf_StallCycles)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (Perf_Flushes)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze_inc),
    .count (Perf_FreezeCycles)
  );
`endif

endmodule : pipeline_controller

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios followed by
// a random run, with expected controls queued at drive time and compared at
// sample time. Perf counter checks are built with PIPELINE_CTRL_PERF_EN.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ID_StallReq;
  logic        ID_FlushReq;
  logic        IF_MemBusy;
  logic        MEM_MemBusy;
  logic        PC_Write, PC_Redirect, IFID_Write, IFID_Flush;
  logic        IDEX_Bubble, IDEX_Write, EXMEM_Write, MEMWB_Write, Stall_Active;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] Perf_StallCycles, Perf_Flushes, Perf_FreezeCycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected vector order:
  // {PC_Write, PC_Redirect, IFID_Write, IFID_Flush, IDEX_Bubble,
  //  IDEX_Write, EXMEM_Write, MEMWB_Write, Stall_Active}
  typedef struct packed {
    logic [8:0] ctl;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic  m_stall2 = 1'b0;
  longint m_stall_cnt = 0;
  longint m_flush_cnt = 0;
  longint m_freeze_cnt = 0;

  pipeline_controller #(.PERF_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_StallReq  (ID_StallReq),
    .ID_FlushReq  (ID_FlushReq),
    .IF_MemBusy   (IF_MemBusy),
    .MEM_MemBusy  (MEM_MemBusy),
    .PC_Write     (PC_Write),
    .PC_Redirect  (PC_Redirect),
    .IFID_Write   (IFID_Write),
    .IFID_Flush   (IFID_Flush),
    .IDEX_Bubble  (IDEX_Bubble),
    .IDEX_Write   (IDEX_Write),
    .EXMEM_Write  (EXMEM_Write),
    .MEMWB_Write  (MEMWB_Write),
    .Stall_Active (Stall_Active)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .Perf_StallCycles  (Perf_StallCycles),
    .Perf_Flushes      (Perf_Flushes),
    .Perf_FreezeCycles (Perf_FreezeCycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected controls straight from the rule table.
  function automatic logic [8:0] model_ctl(input logic r, input logic [1:0] sr,
                                           input logic fr, input logic ib,
                                           input logic mb, input logic st2);
    if (r)         return 9'b0_0_0_1_1_1_1_1_0;
    if (mb)        return 9'b0_0_0_0_0_0_0_0_0;
    if (st2)       return 9'b0_0_0_0_1_1_1_1_1;
    if (sr != 2'd0) return 9'b0_0_0_0_1_1_1_1_0;
    if (fr)        return 9'b1_1_1_1_0_1_1_1_0;
    if (ib)        return 9'b0_0_1_1_0_1_1_1_0;
    return 9'b1_0_1_0_0_1_1_1_0;
  endfunction

  // One cycle: drive, queue expectation, advance model, sample, compare.
  task automatic step(input string tag, input logic r, input logic [1:0] sr,
                      input logic fr, input logic ib, input logic mb);
    exp_t e;
    logic [8:0] obs;
    reset = r; ID_StallReq = sr; ID_FlushReq = fr; IF_MemBusy = ib; MEM_MemBusy = mb;
    e.ctl = model_ctl(r, sr, fr, ib, mb, m_stall2);
    exp_q.push_back(e);
    if (r) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
      m_stall2 = 1'b0;
    end else if (mb) begin
      m_freeze_cnt++;
    end else if (m_stall2) begin
      m_stall_cnt++;
      m_stall2 = 1'b0;
    end else if (sr != 2'd0) begin
      m_stall_cnt++;
      m_stall2 = (sr >= 2'd2);
    end else if (fr) begin
      m_flush_cnt++;
    end
    #3;
    obs = {PC_Write, PC_Redirect, IFID_Write, IFID_Flush, IDEX_Bubble,
           IDEX_Write, EXMEM_Write, MEMWB_Write, Stall_Active};
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(obs), 64'(e.ctl));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag);
`ifdef PIPELINE_CTRL_PERF_EN
    check({tag, "_stall_cnt"},  64'(Perf_StallCycles),  64'(m_stall_cnt));
    check({tag, "_flush_cnt"},  64'(Perf_Flushes),      64'(m_flush_cnt));
    check({tag, "_freeze_cnt"}, 64'(Perf_FreezeCycles), 64'(m_freeze_cnt));
`else
    checks = checks;
    if (tag.len() == 0) $display("note: empty perf tag");
`endif
  endtask

  initial begin
    reset = 1'b1; ID_StallReq = 2'd0; ID_FlushReq = 1'b0; IF_MemBusy = 1'b0; MEM_MemBusy = 1'b0;
    @(posedge clk);
    #1;

    // Reset values, then idle run
    step("reset0", 1, 2'd0, 0, 0, 0);
    step("reset_busy", 1, 2'd2, 1, 1, 1);
    step("idle", 0, 2'd0, 0, 0, 0);
    check("stall_active_idle", 64'(Stall_Active), 64'd0);

    // One-cycle stall
    step("stall1", 0, 2'd1, 0, 0, 0);
    step("stall1_after", 0, 2'd0, 0, 0, 0);

    // Two-cycle stall, request withdrawn after first cycle
    step("stall2_a", 0, 2'd2, 0, 0, 0);
    step("stall2_b", 0, 2'd0, 1, 1, 0);
    step("stall2_done", 0, 2'd0, 0, 0, 0);

    // Request value 3 behaves as 2
    step("stall3_a", 0, 2'd3, 0, 0, 0);
    step("stall3_b", 0, 2'd0, 0, 0, 0);
    step("stall3_done", 0, 2'd0, 0, 0, 0);

    // Stall 2 with a 3-cycle freeze in the middle, counters from a clean reset
    step("pre_freeze_rst", 1, 2'd0, 0, 0, 0);
    step("frz_stall_a", 0, 2'd2, 0, 0, 0);
    step("frz_1", 0, 2'd0, 0, 0, 1);
    step("frz_2", 0, 2'd1, 1, 0, 1);
    step("frz_3", 0, 2'd0, 0, 1, 1);
    step("frz_stall_b", 0, 2'd0, 0, 0, 0);
    check_perf("freeze_scn");
    step("frz_done", 0, 2'd0, 0, 0, 0);

    // Stall beats flush; flush beats fetch wait
    step("flush_vs_stall", 0, 2'd1, 1, 0, 0);
    step("flush_vs_ifbusy", 0, 2'd0, 1, 1, 0);
    step("flush_plain", 0, 2'd0, 1, 0, 0);

    // Instruction fetch wait for two cycles
    step("ifbusy_1", 0, 2'd0, 0, 1, 0);
    step("ifbusy_2", 0, 2'd0, 0, 1, 0);

    // Reset while in the second stall cycle
    step("rst_stall2_a", 0, 2'd2, 0, 0, 0);
    step("rst_in_stall2", 1, 2'd0, 0, 0, 0);
    step("after_rst", 0, 2'd0, 0, 0, 0);
    check_perf("after_rst");

    // Random traffic with occasional freezes and resets
    for (int i = 0; i < 300; i++) begin
      logic r, fr, ib, mb;
      logic [1:0] sr;
      r  = ($urandom_range(0, 39) == 0);
      sr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      fr = ($urandom_range(0, 4) == 0);
      ib = ($urandom_range(0, 4) == 0);
      mb = ($urandom_range(0, 5) == 0);
      step("rand", r, sr, fr, ib, mb);
    end
    check_perf("final");
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_controller
